photon_port_arb: RTL and testbench

PHOTON_PORT_ARB -- requirements
Module: photon_port_arb

---
 rtl/photon_port_arb.sv | 126 ++++++++++++
 tb/tb_photon_port_arb.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/photon_port_arb.sv
// photon_port_arb: four-way round-robin burst arbiter feeding a single
// 32-bit photon port register through a valid/ready output stage.
// Optional build macro PHOTON_ARB_HDR_EN: when defined, every burst is
// preceded by a header word {8'hFF, 6'b0, grant_id, burst_cnt}.
module photon_port_arb #(
    parameter int BURST_MAX = 16
) (
    input  logic         OPB_Clk,
    input  logic         OPB_Rst,
    input  logic         enable,
    input  logic [3:0]   req_valid,
    input  logic [127:0] req_data,
    output logic [3:0]   req_ready,
    output logic [31:0]  port_data,
    output logic         port_valid,
    input  logic         port_ready,
    output logic [1:0]   grant_id,
    output logic [15:0]  burst_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef PHOTON_ARB_HDR_EN
        HDR  = 2'd1,
`endif
        SEND = 2'd2
    } state_t;

    state_t      state_reg;
    logic [1:0]  rr_ptr_reg;
    logic [7:0]  beat_cnt_reg;

    logic [31:0] lane [4];
    logic [3:0]  valid_rot;
    logic [1:0]  pick_off;
    logic [1:0]  pick_id;
    logic        load_ok;
    logic        sel_valid;
    logic        accept;
    logic        last_beat;
    logic        burst_end;

    // The output register may take a new word when empty or being drained.
    assign load_ok   = !port_valid || port_ready;
    assign sel_valid = req_valid[grant_id];
    assign accept    = (state_reg == SEND) && load_ok && sel_valid;
    // beat_cnt counts accepted words; this accept is the last one allowed.
    assign last_beat = (beat_cnt_reg == 8'(BURST_MAX - 1));
    // A burst also ends when the grantee has nothing more, even with zero words sent.
    assign burst_end = (state_reg == SEND) && load_ok && (!sel_valid || last_beat);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi]      = req_data[32*gi +: 32];
            // valid_rot[0] is the requester at rr_ptr, so the lowest set bit wins.
            assign valid_rot[gi] = req_valid[rr_ptr_reg + 2'(gi)];
            assign req_ready[gi] = accept && (grant_id == 2'(gi));
        end
    endgenerate

    // Find the first valid requester at or after rr_ptr, wrapping modulo 4.
    always_comb begin
        pick_off = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (valid_rot[k]) begin
                pick_off = 2'(k);
            end
        end
        pick_id = rr_ptr_reg + pick_off;
    end

    // Arbitration FSM together with the registered output stage.
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            state_reg    <= IDLE;
            rr_ptr_reg   <= 2'd0;
            beat_cnt_reg <= 8'd0;
            grant_id     <= 2'd0;
            burst_cnt    <= 16'd0;
            port_data    <= 32'd0;
            port_valid   <= 1'b0;
        end else begin
            // A consumed word is dropped unless a new one is loaded below.
            if (port_ready) begin
                port_valid <= 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    if (enable && (|req_valid)) begin
                        grant_id     <= pick_id;
                        beat_cnt_reg <= 8'd0;
`ifdef PHOTON_ARB_HDR_EN
                        state_reg    <= HDR;
`else
                        state_reg    <= SEND;
`endif
                    end
                end
`ifdef PHOTON_ARB_HDR_EN
                HDR: begin
                    if (load_ok) begin
                        port_data  <= {8'hFF, 6'b0, grant_id, burst_cnt};
                        port_valid <= 1'b1;
                        state_reg  <= SEND;
                    end
                end
`endif
                SEND: begin
                    if (accept) begin
                        port_data    <= lane[grant_id];
                        port_valid   <= 1'b1;
                        beat_cnt_reg <= beat_cnt_reg + 8'd1;
                    end
                    if (burst_end) begin
                        rr_ptr_reg <= grant_id + 2'd1;
                        burst_cnt  <= burst_cnt + 16'd1;
                        state_reg  <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_photon_port_arb.sv
// tb_photon_port_arb: table-driven scenarios with a word scoreboard for
// photon_port_arb (BURST_MAX = 16). Honors PHOTON_ARB_HDR_EN like the design.
module tb_photon_port_arb;

    logic         OPB_Clk = 1'b0;
    logic         OPB_Rst = 1'b0;
    logic         enable = 1'b0;
    logic [3:0]   req_valid = 4'd0;
    logic [127:0] req_data = '0;
    logic [3:0]   req_ready;
    logic [31:0]  port_data;
    logic         port_valid;
    logic         port_ready = 1'b0;
    logic [1:0]   grant_id;
    logic [15:0]  burst_cnt;

    photon_port_arb #(.BURST_MAX(16)) dut (
        .OPB_Clk    (OPB_Clk),
        .OPB_Rst    (OPB_Rst),
        .enable     (enable),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .port_data  (port_data),
        .port_valid (port_valid),
        .port_ready (port_ready),
        .grant_id   (grant_id),
        .burst_cnt  (burst_cnt)
    );

    always #5 OPB_Clk = ~OPB_Clk;

    // One scenario: requester word counts and start cycles, port stall window,
    // enable drop cycle, random ready, and the expected grant order.
    typedef struct packed {
        logic [3:0][7:0] rem;
        logic [3:0][7:0] start;
        logic [7:0]      stall_at;
        logic [7:0]      stall_len;
        logic [7:0]      en_off;
        logic            rdy_rand;
        logic [3:0]      n_grants;
        logic [7:0][1:0] grants;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          words = 0;
    int          cyc;
    int          rem_c [4];
    int          nseq [4];
    int          start_c [4];
    int          stall_at, stall_len, en_off;
    bit          rdy_rand;
    bit          prev_hold;
    logic [31:0] prev_data;
    logic [31:0] exp_q [$];
    vec_t        vecs [6];

    function automatic vec_t mk(input logic [31:0] rem, input logic [31:0] start,
                                input int sa, input int sl, input int eo,
                                input bit rr, input int n, input logic [15:0] gr);
        vec_t v;
        v.rem       = rem;
        v.start     = start;
        v.stall_at  = 8'(sa);
        v.stall_len = 8'(sl);
        v.en_off    = 8'(eo);
        v.rdy_rand  = rr;
        v.n_grants  = 4'(n);
        v.grants    = gr;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Expected port words for a grant order: optional header, then up to 16 words.
    task automatic push_grants(input vec_t v);
        int mrem [4];
        int mseq [4];
        int g, cnt;
        for (int i = 0; i < 4; i++) begin
            mrem[i] = int'(v.rem[i]);
            mseq[i] = 1;
        end
        for (int k = 0; k < int'(v.n_grants); k++) begin
            g = int'(v.grants[k]);
`ifdef PHOTON_ARB_HDR_EN
            exp_q.push_back({8'hFF, 6'b0, 2'(g), 16'(k)});
`endif
            cnt = (mrem[g] < 16) ? mrem[g] : 16;
            for (int j = 0; j < cnt; j++) begin
                exp_q.push_back({8'(g), 24'(mseq[g])});
                mseq[g]++;
            end
            mrem[g] -= cnt;
        end
    endtask

    task automatic load_vec(input vec_t v);
        for (int i = 0; i < 4; i++) begin
            rem_c[i]   = int'(v.rem[i]);
            start_c[i] = int'(v.start[i]);
            nseq[i]    = 1;
        end
        stall_at  = int'(v.stall_at);
        stall_len = int'(v.stall_len);
        en_off    = int'(v.en_off);
        rdy_rand  = v.rdy_rand;
        cyc       = 0;
    endtask

    task automatic drive;
        for (int i = 0; i < 4; i++) begin
            req_valid[i] = (cyc >= start_c[i]) && (rem_c[i] > 0);
            req_data[32*i +: 32] = {8'(i), 24'(nseq[i])};
        end
        enable = (cyc < en_off);
        if (cyc >= stall_at && cyc < stall_at + stall_len)
            port_ready = 1'b0;
        else if (rdy_rand)
            port_ready = ($urandom_range(0, 3) != 0);
        else
            port_ready = 1'b1;
    endtask

    // One clock: drive, observe at the falling edge, account accepts after the rise.
    task automatic step;
        logic [3:0]  acc;
        logic [31:0] e;
        drive();
        @(negedge OPB_Clk);
        if (prev_hold) begin
            check("hold_valid", 64'(port_valid), 64'd1);
            check("hold_data", 64'(port_data), 64'(prev_data));
        end
        if (port_valid && !port_ready)
            check("stall_req_ready", 64'(req_ready), 64'd0);
        check("ready_legal", 64'(((req_ready & ~req_valid) != 4'd0) || ($countones(req_ready) > 1)), 64'd0);
        if (port_valid && port_ready) begin
            words++;
            $display("word %0d cyc %0d data=%h grant=%0d", words, cyc, port_data, grant_id);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_word actual=%h required=none", port_data);
            end else begin
                e = exp_q.pop_front();
                check("port_word", 64'(port_data), 64'(e));
            end
        end
        prev_hold = port_valid && !port_ready;
        prev_data = port_data;
        acc = req_ready;
        @(posedge OPB_Clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) begin
                rem_c[i]--;
                nseq[i]++;
            end
        end
        cyc++;
    endtask

    // Called just after a rising edge; checks outputs clear before any clock.
    task automatic apply_reset;
        OPB_Rst    = 1'b1;
        req_valid  = 4'd0;
        enable     = 1'b0;
        port_ready = 1'b0;
        prev_hold  = 1'b0;
        #1;
        check("reset_outputs", 64'({port_valid, port_data, req_ready, grant_id, burst_cnt}), 64'd0);
        @(posedge OPB_Clk);
        #1;
        OPB_Rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        n = int'(v.n_grants);
        apply_reset();
        load_vec(v);
        exp_q.delete();
        push_grants(v);
        repeat (200) step();
        check("leftover_words", 64'(exp_q.size()), 64'd0);
        check("burst_cnt_end", 64'(burst_cnt), 64'(n));
        check("grant_id_end", 64'(grant_id), 64'(v.grants[n-1]));
        check("port_valid_end", 64'(port_valid), 64'd0);
    endtask

    initial begin
        // rem/start: byte i is requester i; grants: 2 bits per burst, first in [1:0].
        vecs[0] = mk(32'h00000014, 32'h0, 0, 0, 255, 1'b0, 2, 16'h0000); // single lane, 20 words
        vecs[1] = mk(32'h10101020, 32'h0, 0, 0, 255, 1'b0, 5, 16'h00E4); // 0,1,2,3,0
        vecs[2] = mk(32'h0000000A, 32'h0, 8, 5, 255, 1'b0, 1, 16'h0000); // 5-cycle stall
        vecs[3] = mk(32'h02030002, 32'h28000028, 0, 0, 255, 1'b0, 3, 16'h000E); // 2 drops, then 3 before 0
        vecs[4] = mk(32'h00001E00, 32'h0, 0, 0, 5, 1'b0, 1, 16'h0001); // enable falls mid-burst
        vecs[5] = mk(32'h14000305, 32'h0, 0, 0, 255, 1'b1, 4, 16'h00F4); // random port_ready

        @(posedge OPB_Clk);
        #1;
        for (int t = 0; t < 6; t++) begin
            run_vec(vecs[t]);
        end

        // Reset pulse in the middle of a burst from requester 0.
        apply_reset();
        load_vec(mk(32'h0000001E, 32'h0, 0, 0, 255, 1'b0, 1, 16'h0000));
        exp_q.delete();
        push_grants(mk(32'h0000001E, 32'h0, 0, 0, 255, 1'b0, 1, 16'h0000));
        repeat (6) step();
        check("pre_reset_valid", 64'(port_valid), 64'd1);
        OPB_Rst   = 1'b1;
        prev_hold = 1'b0;
        #1;
        check("midburst_reset_outputs", 64'({port_valid, port_data, req_ready, grant_id, burst_cnt}), 64'd0);
        exp_q.delete();
        load_vec(mk(32'h00050500, 32'h0, 0, 0, 255, 1'b0, 2, 16'h0009));
        push_grants(mk(32'h00050500, 32'h0, 0, 0, 255, 1'b0, 2, 16'h0009));
        drive();
        @(posedge OPB_Clk);
        #1;
        OPB_Rst = 1'b0;
        repeat (60) step();
        check("post_reset_leftover", 64'(exp_q.size()), 64'd0);
        check("post_reset_burst_cnt", 64'(burst_cnt), 64'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
